// File: rtl/serial_frame_rx_if.sv
// Purpose : bundles the serial receive link with its deframed word and status outputs.
// Latency : none; wires only.
// Backpressure: none; the receiver is paced solely by din_vld.
// Ports   : master = link driver / result consumer; slave = serial_frame_rx.
//           din, din_vld      serial bit and its strobe (master -> slave)
//           data_out, data_vld, frame_err, parity_err, busy  (slave -> master)
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              din;
    logic              din_vld;
    logic [DATA_W-1:0] data_out;
    logic              data_vld;
    logic              frame_err;
    logic              parity_err;
    logic              busy;

    modport master (
        output din,
        output din_vld,
        input  data_out,
        input  data_vld,
        input  frame_err,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  din,
        input  din_vld,
        output data_out,
        output data_vld,
        output frame_err,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/serial_frame_rx.sv
// Purpose : bit-serial frame receiver; start(0) + DATA_W bits LSB first [+ parity] + stop(1).
// Latency : data_vld / frame_err / parity_err pulse one cycle after the stop-bit strobe.
// Backpressure: none; advances only on din_vld, holds state and drops pulses otherwise.
// Ports   : clk, rst (synchronous, active-high); bus = serial_frame_rx_if.slave
//           (din, din_vld in; data_out, data_vld, frame_err, parity_err, busy out).
// Config  : define SERIAL_RX_PARITY_EN to build the parity bit stage; PARITY_ODD picks
//           odd (1) or even (0) parity. Without the macro parity_err is tied to 0.
//           The interface instance must use the same DATA_W as this module.
module serial_frame_rx #(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst,
    serial_frame_rx_if.slave  bus
);
    localparam int CW = $clog2(DATA_W + 1);

`ifdef SERIAL_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DATA   = 3'd1,
        ST_PARITY = 3'd2,
        ST_STOP   = 3'd3,
        ST_BREAK  = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_STOP  = 2'd2,
        ST_BREAK = 2'd3
    } state_t;
`endif

    state_t            state, state_n;
    logic [CW-1:0]     cnt, cnt_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic [DATA_W-1:0] dout, dout_n;
    logic              dvld, dvld_n;
    logic              ferr, ferr_n;
    logic              perr, perr_n;
    logic              pbad, pbad_n;   // parity mismatch latched at the parity bit

`ifndef SERIAL_RX_PARITY_EN
    // No parity stage: the odd/even setting has nothing to act on.
    logic unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            shreg <= '0;
            dout  <= '0;
            dvld  <= 1'b0;
            ferr  <= 1'b0;
            perr  <= 1'b0;
            pbad  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            shreg <= shreg_n;
            dout  <= dout_n;
            dvld  <= dvld_n;
            ferr  <= ferr_n;
            perr  <= perr_n;
            pbad  <= pbad_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        dout_n  = dout;
        dvld_n  = 1'b0;
        ferr_n  = 1'b0;
        perr_n  = 1'b0;
        pbad_n  = pbad;

        if (bus.din_vld) begin
            unique case (state)
                ST_IDLE: begin
                    if (!bus.din) begin
                        state_n = ST_DATA;
                        cnt_n   = '0;
                        pbad_n  = 1'b0;
                    end
                end

                ST_DATA: begin
                    for (int i = 0; i < DATA_W; i++) begin
                        if (cnt == CW'(i)) begin
                            shreg_n[i] = bus.din;
                        end
                    end
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                        state_n = ST_PARITY;
`else
                        state_n = ST_STOP;
`endif
                    end
                end

`ifdef SERIAL_RX_PARITY_EN
                ST_PARITY: begin
                    // XOR over data + parity bit must equal 1 for odd, 0 for even.
                    pbad_n  = ((^shreg) ^ bus.din) != (PARITY_ODD != 0);
                    state_n = ST_STOP;
                end
`endif

                ST_STOP: begin
                    if (bus.din) begin
                        state_n = ST_IDLE;
                        if (pbad) begin
                            perr_n = 1'b1;
                        end else begin
                            dout_n = shreg;
                            dvld_n = 1'b1;
                        end
                    end else begin
                        // Framing error outranks any parity result.
                        ferr_n  = 1'b1;
                        state_n = ST_BREAK;
                    end
                end

                ST_BREAK: begin
                    // A held-low line must return high before a start bit counts.
                    if (bus.din) begin
                        state_n = ST_IDLE;
                    end
                end

                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign bus.data_out  = dout;
    assign bus.data_vld  = dvld;
    assign bus.frame_err = ferr;
`ifdef SERIAL_RX_PARITY_EN
    assign bus.parity_err = perr;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign bus.busy      = (state != ST_IDLE);
endmodule
